// File: rtl/score_keeper.sv
// Game-state and scoring engine for the scoreboard renderer: IDLE/PLAY/OVER sequencing,
// saturating 4-digit BCD score with combo multiplier, combo counter and BCD countdown.
`timescale 1ns/1ps

module score_keeper #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter logic [7:0]  GAME_SECONDS = 8'h60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic [9:0] combo_count,
  output logic [7:0] time_left,
  output logic       game_over,
  output logic       game_menu
);

  localparam int unsigned TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_HZ - 1);
  localparam logic [9:0] COMBO_MAX = 10'd999;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0][3:0] r_score, w_score_nxt, w_score_inc;
  logic [9:0]      r_combo, w_combo_nxt;
  logic [7:0]      r_time, w_time_nxt, w_time_dec;
  logic [TW-1:0]   r_tick, w_tick_nxt;
  logic            r_over, r_menu;
  logic [2:0]      w_mult;
  logic [4:0]      w_sum;
  logic [3:0]      w_carry;
  logic            w_inc_ovf;
  logic            w_tick;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_score <= '0;
      r_combo <= '0;
      r_time  <= GAME_SECONDS;
      r_tick  <= '0;
      r_over  <= 1'b0;
      r_menu  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_score <= w_score_nxt;
      r_combo <= w_combo_nxt;
      r_time  <= w_time_nxt;
      r_tick  <= w_tick_nxt;
      r_over  <= (w_state_nxt == S_OVER);
      r_menu  <= (w_state_nxt == S_IDLE);
    end
  end

  // Multiplier bands match the renderer's multiplier glyph.
  always_comb begin
    if (r_combo <= 10'd5)       w_mult = 3'd1;
    else if (r_combo <= 10'd13) w_mult = 3'd2;
    else if (r_combo <= 10'd24) w_mult = 3'd3;
    else if (r_combo <= 10'd38) w_mult = 3'd4;
    else                        w_mult = 3'd5;
  end

  // Single-cycle ripple BCD add; a carry out of the thousands digit means saturation.
  always_comb begin
    w_carry     = {1'b0, w_mult};
    w_sum       = '0;
    w_score_inc = '0;
    for (int i = 0; i < 4; i++) begin
      w_sum = {1'b0, r_score[i]} + {1'b0, w_carry};
      if (w_sum > 5'd9) begin
        w_score_inc[i] = w_sum[3:0] - 4'd10;
        w_carry        = 4'd1;
      end else begin
        w_score_inc[i] = w_sum[3:0];
        w_carry        = 4'd0;
      end
    end
    w_inc_ovf = (w_carry != 4'd0);
  end

  assign w_time_dec = (r_time[3:0] == 4'd0) ? {r_time[7:4] - 4'd1, 4'd9}
                                            : {r_time[7:4], r_time[3:0] - 4'd1};
  assign w_tick     = (r_tick == TICK_MAX);

  // NOTE: every signal gets its hold value first so no branch can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    w_combo_nxt = r_combo;
    w_time_nxt  = r_time;
    w_tick_nxt  = r_tick;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_PLAY;
          w_score_nxt = '0;
          w_combo_nxt = '0;
          w_time_nxt  = GAME_SECONDS;
          w_tick_nxt  = '0;
        end
      end
      S_PLAY: begin
        if (miss) begin
          w_combo_nxt = '0;
        end else if (hit) begin
          w_score_nxt = w_inc_ovf ? {4{4'd9}} : w_score_inc;
          w_combo_nxt = (r_combo == COMBO_MAX) ? r_combo : r_combo + 10'd1;
        end
        if (w_tick) begin
          w_tick_nxt = '0;
          w_time_nxt = w_time_dec;
          if (w_time_dec == 8'h00) w_state_nxt = S_OVER;
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
      S_OVER: begin
        if (start) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign score0      = r_score[0];
  assign score1      = r_score[1];
  assign score2      = r_score[2];
  assign score3      = r_score[3];
  assign combo_count = r_combo;
  assign time_left   = r_time;
  assign game_over   = r_over;
  assign game_menu   = r_menu;

endmodule
